alu_md: RTL
===========

# alu_md

Parametrised successor of the single-cycle datapath ALU. It keeps the combinational ALUFun datapath (add/sub, logic, shift, compare), generalised to WIDTH bits. It adds a sequential multiply/divide unit with HI/LO registers, a start/busy/done handshake and signed/unsigned modes. It sits in the EX stage, and the control unit stalls issue while busy is high.

## Interface

- WIDTH, 32, datapath width; must be a power of two, at least 8
- SHW, $clog2(WIDTH), shift-amount width (derived)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- A  in  WIDTH  operand A; also the shift amount (A[SHW-1:0])
- B  in  WIDTH  operand B
- ALUFun  in  6  combinational op select
- Sign  in  1  1 = signed arithmetic/compare/mult/div
- start  in  1  request a mult/div/move op; sampled only when busy=0
- md_op  in  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO
- Z  out  WIDTH  combinational ALU result
- busy  out  1  multi-cycle op in progress
- done  out  1  one-cycle pulse when HI/LO are updated
- HI  out  WIDTH  HI register: mult upper half, div remainder
- LO  out  WIDTH  LO register: mult lower half, div quotient

## Operation

- Z is purely combinational. It is independent of busy and never stalls.
- ALUFun[5:4] = 00: arithmetic.
  - bit0 = 0: A+B; bit0 = 1: A−B.
  - Result wraps modulo 2^WIDTH.
- ALUFun[5:4] = 01: logic.
  - 1000 AND, 1110 OR, 0110 XOR, 0001 NOR, 1010 pass A.
  - Any other code passes A.
- ALUFun[5:4] = 10: shift B by A[SHW-1:0].
  - [1:0] = 00 SLL, 01 SRL, 11 SRA; 10 acts as SLL.
- ALUFun[5:4] = 11: compare; Z = {WIDTH-1 zeros, flag}. Flag by [3:1]:
  - 001 EQ (A==B), 000 NE (A!=B), 010 LT (A<B per Sign).
  - 101 LTZ (A<0), 110 LEZ (A<=0), 111 GTZ (A>0); all compare A against zero, signed.
  - Any other code gives flag 0.
- Mult/div FSM states: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 with MULT/DIV: latch |A| and |B| (magnitudes when Sign=1, raw otherwise), latch the result signs, clear the counter, go to RUN.
  - start=1 with MTHI/MTLO: write A to HI/LO at that edge, go to DONE.
- RUN: one radix-2 step per cycle for exactly WIDTH cycles.
  - MULT: shift-add.
  - DIV: restoring; one quotient bit per cycle.
  - Counter wraps at WIDTH−1, then go to FIX.
- FIX:
  - Apply sign correction. MULT: negate the 2·WIDTH product if signs differ. DIV: quotient negative if signs differ; remainder takes the dividend's sign.
  - Write HI/LO at this edge, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Divide by zero (B==0): no RUN steps are skipped. Result is LO = all ones and HI = A (raw dividend), regardless of Sign.
- Signed overflow DIV (most negative / −1): LO = most negative, HI = 0.
- start while busy=1 is ignored; no queuing and no error.

## Timing

- Reset values: Z follows inputs; busy=0, done=0, HI=0, LO=0; FSM in IDLE; counter 0.
- MULT/DIV: start sampled at edge E0.
  - busy is high from E0 through E0+WIDTH+1, i.e. WIDTH+1 cycles (RUN + FIX).
  - HI/LO update at edge E0+WIDTH+1.
  - done is high during the following cycle; busy=0 in that cycle.
- A new start is accepted in the done cycle. Back-to-back throughput is WIDTH+2 cycles per op.
- MTHI/MTLO: HI/LO update at E0. busy never rises. done is high the next cycle.
- Operands are latched at E0; A/B/Sign/md_op may change afterwards without effect.
- reset=1 at any edge, including mid-RUN: abort, clear HI/LO, go to IDLE. done is not pulsed.

## Test plan

- Combinational ALU (WIDTH=32):
  - A=5, B=7, ALUFun=000001 → Z=0xFFFFFFFE.
  - ALUFun=110101, Sign=1 → Z=1.
  - A=0x80000000, B=0xF0000000, ALUFun=100011, Sign=1 (SRA by A[4:0]=0) → Z=0xF0000000.
  - A=4, B=0x80000000, ALUFun=100011 (SRA) → Z=0xF8000000.
- Signed MULT: A=−3, B=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. busy high 33 cycles; done in cycle 34 after start.
- Unsigned MULT: A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV cases:
  - Unsigned 100/7 → LO=14, HI=2.
  - Signed −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - A=9, B=0 → LO=0xFFFFFFFF, HI=9.
- Handshake:
  - start asserted every cycle during a MULT → exactly one op completes.
  - MTLO A=0x1234 → LO=0x1234 next cycle, busy stays 0.
- Reset mid-op: assert reset at RUN cycle 10 → HI=LO=0, busy=0, no done pulse; a subsequent DIV completes normally.

Source files
------------

// File: rtl/alu_md.sv
// alu_md: combinational ALUFun datapath plus a sequential radix-2 multiply/divide unit
// with HI/LO registers and a start/busy/done handshake.
module alu_md #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [5:0]       ALUFun,
   input  logic             Sign,
   input  logic             start,
   input  logic [1:0]       md_op,
   output logic [WIDTH-1:0] Z,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);
   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
   state_t             r_state, w_next;
   logic [SHW-1:0]     r_cnt;
   logic [WIDTH-1:0]   r_u, r_l, r_b, r_araw, r_hi, r_lo;
   logic               r_div, r_nq, r_nr, r_dz;
   logic [WIDTH-1:0]   w_arith, w_logic, w_shift, w_sra, w_mag_a, w_mag_b, w_fhi, w_flo;
   logic [WIDTH:0]     w_sum, w_sh, w_dif;
   logic [2*WIDTH-1:0] w_prod;
   logic               w_lt, w_flag, w_idle, w_go, w_mv;
   always_comb begin
      w_arith = ALUFun[0] ? A - B : A + B;
      w_logic = ALUFun[3:0] == 4'b1000 ? A & B :
                ALUFun[3:0] == 4'b1110 ? A | B :
                ALUFun[3:0] == 4'b0110 ? A ^ B :
                ALUFun[3:0] == 4'b0001 ? ~(A | B) : A;
      // kept in its own assignment so the shift stays arithmetic
      w_sra   = $signed(B) >>> A[SHW-1:0];
      w_shift = ALUFun[1:0] == 2'b01 ? B >> A[SHW-1:0] :
                ALUFun[1:0] == 2'b11 ? w_sra : B << A[SHW-1:0];
      w_lt    = Sign ? $signed(A) < $signed(B) : A < B;
      w_flag  = ALUFun[3:1] == 3'b001 ? A == B :
                ALUFun[3:1] == 3'b000 ? A != B :
                ALUFun[3:1] == 3'b010 ? w_lt :
                ALUFun[3:1] == 3'b101 ? A[WIDTH-1] :
                ALUFun[3:1] == 3'b110 ? A[WIDTH-1] | (A == '0) :
                ALUFun[3:1] == 3'b111 ? ~A[WIDTH-1] & (A != '0) : 1'b0;
      Z = ALUFun[5:4] == 2'b00 ? w_arith :
          ALUFun[5:4] == 2'b01 ? w_logic :
          ALUFun[5:4] == 2'b10 ? w_shift : {{(WIDTH-1){1'b0}}, w_flag};
   end
   always_comb begin
      w_idle  = r_state == IDLE || r_state == DONE;
      w_go    = w_idle & start & ~md_op[1];
      w_mv    = w_idle & start & md_op[1];
      w_mag_a = Sign && A[WIDTH-1] ? -A : A;
      w_mag_b = Sign && B[WIDTH-1] ? -B : B;
      w_sum   = {1'b0, r_u} + {1'b0, r_l[0] ? r_b : '0};
      w_sh    = {r_u, r_l[WIDTH-1]};
      w_dif   = w_sh - {1'b0, r_b};
      w_prod  = r_nq ? -{r_u, r_l} : {r_u, r_l};
      w_fhi   = !r_div ? w_prod[2*WIDTH-1:WIDTH] : r_dz ? r_araw : r_nr ? -r_u : r_u;
      w_flo   = !r_div ? w_prod[WIDTH-1:0] : r_dz ? '1 : r_nq ? -r_l : r_l;
   end
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else r_state <= w_next;
   end
   always_comb begin
      w_next = r_state == RUN ? (r_cnt == SHW'(WIDTH - 1) ? FIX : RUN) :
               r_state == FIX ? DONE :
               w_go ? RUN : w_mv ? DONE : IDLE;
   end
   always_comb begin
      busy = r_state == RUN || r_state == FIX;
      done = r_state == DONE;
      HI   = r_hi;
      LO   = r_lo;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt  <= '0;
         r_hi   <= '0;
         r_lo   <= '0;
         r_u    <= '0;
         r_l    <= '0;
         r_b    <= '0;
         r_araw <= '0;
         r_div  <= 1'b0;
         r_nq   <= 1'b0;
         r_nr   <= 1'b0;
         r_dz   <= 1'b0;
      end else begin
         if (w_go) begin
            r_u    <= '0;
            r_l    <= w_mag_a;
            r_b    <= w_mag_b;
            r_araw <= A;
            r_div  <= md_op[0];
            r_nq   <= Sign & (A[WIDTH-1] ^ B[WIDTH-1]);
            r_nr   <= Sign & A[WIDTH-1];
            r_dz   <= B == '0;
            r_cnt  <= '0;
         end
         if (w_mv & ~md_op[0]) r_hi <= A;
         if (w_mv & md_op[0]) r_lo <= A;
         // r_u/r_l hold product high/low for MULT, remainder/shifting quotient for DIV
         if (r_state == RUN) begin
            r_cnt <= r_cnt + 1'b1;
            if (!r_div) begin
               r_u <= w_sum[WIDTH:1];
               r_l <= {w_sum[0], r_l[WIDTH-1:1]};
            end else if (!w_dif[WIDTH]) begin
               r_u <= w_dif[WIDTH-1:0];
               r_l <= {r_l[WIDTH-2:0], 1'b1};
            end else begin
               r_u <= w_sh[WIDTH-1:0];
               r_l <= {r_l[WIDTH-2:0], 1'b0};
            end
         end
         if (r_state == FIX) begin
            r_hi <= w_fhi;
            r_lo <= w_flo;
         end
      end
   end
endmodule
